// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, state type,
// default latencies and the start-class decode helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

  localparam int unsigned MD_MULT_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF  = 10;

  // Ops that occupy the unit for several cycles (as opposed to mthi/mtlo).
  function automatic logic is_md_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath; the sequencer only models latency,
// the full result is produced here in one cycle.
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a} * {32'b0, b};
  assign sa     = a;
  assign sb     = b;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    div0   = 1'b0;
    case (md_op)
      MD_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          // Quotient overflows back to INT_MIN; handled explicitly.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = sa / sb;
          res_hi = sa % sb;
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          div0 = 1'b1;
        end else begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer and HI/LO owner: models fixed latency with a busy
// counter, commits results to HI/LO and raises the D-stage stall.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              pend_div0_q, pend_div0_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [31:0]       alu_hi;
  logic [31:0]       alu_lo;
  logic              alu_div0;

  md_alu u_md_alu (
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .res_hi (alu_hi),
    .res_lo (alu_lo),
    .div0   (alu_div0)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_div0_d = pend_div0_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_md_start(md_op)) begin
            state_d     = StRun;
            count_d     = is_div(md_op) ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
            pend_hi_d   = alu_hi;
            pend_lo_d   = alu_lo;
            pend_div0_d = alu_div0;
          end else if (md_op == MD_MTHI) begin
            hi_d = a;
          end else if (md_op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        // A start arriving here is dropped; stall_D keeps it from happening.
        if (count_q == CntW'(1)) begin
          state_d = StIdle;
          count_d = '0;
          if (!pend_div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          count_d = count_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_div0_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_div0_q <= pend_div0_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign stall_D = md_use_D & (busy | (start & is_md_start(md_op)));
  assign hi      = hi_q;
  assign lo      = lo_q;

  start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy))
    else $error("md_sched: start accepted while an operation is in flight");

endmodule
